// File: rtl/sample_tick_pkg.sv
// -----------------------------------------------------------------------------
// sample_tick_pkg
//
// Shared definitions for the sampling-tick timebase that sits beside the
// scale-to-period lookup and triggers the AD7276 acquisition front end.
//
// Contents:
//   tick_state_t    - timebase FSM state (IDLE / RUN / DRAIN), fixed encoding
//                     so the debug state output is stable across builds.
//   MIN_PERIOD_DEF  - default smallest honoured period in clock cycles.
//   CNT_W_DEF       - default width of the period input / cycle counter.
//   OVR_W_DEF       - default width of the overrun counter.
// -----------------------------------------------------------------------------
package sample_tick_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // timebase stopped, counter held at zero
        RUN   = 2'd1,   // counting, ticks issued at each period boundary
        DRAIN = 2'd2    // disabled with a request outstanding; wait for ack
    } tick_state_t;

    // A period of 1 would make every cycle a boundary and the counter compare
    // (period - 1) degenerate; 2 is the smallest period that still produces a
    // distinct idle cycle between ticks.
    localparam int MIN_PERIOD_DEF = 2;

    localparam int CNT_W_DEF = 32;
    localparam int OVR_W_DEF = 16;

endpackage : sample_tick_pkg

// File: rtl/sample_tick_gen.sv
// -----------------------------------------------------------------------------
// sample_tick_gen
//
// Turns a sampling period expressed in aclk cycles into a strictly periodic
// one-cycle tick, and turns every tick into a conversion request towards the
// AD7276 acquisition front end. Period changes take effect only at a period
// boundary, so a running period is never shortened or stretched. Ticks that
// arrive while the previous request is still unacknowledged are counted as
// overruns instead of stacking up a second request.
//
// Parameters:
//   CNT_W       width of period_in and of the internal cycle counter
//   MIN_PERIOD  smallest honoured period; smaller inputs are clamped up
//   OVR_W       width of the saturating overrun counter
//
// Ports:
//   aclk         in   single clock, all logic on the rising edge
//   aresetn      in   asynchronous active-low reset
//   enable       in   level, high runs the timebase
//   period_in    in   desired period in aclk cycles, may change at any time
//   clear_ovr    in   one-cycle pulse, clears overrun_cnt
//   conv_ack     in   one-cycle pulse from the converter, accepts the request
//   tick         out  one-cycle pulse, once per period
//   conv_req     out  level, high from tick until acknowledged
//   overrun_cnt  out  saturating count of ticks that found conv_req high
//   active       out  high while in RUN or DRAIN
//   state_dbg    out  current FSM state, for observation only
//
// Request handshake (conv_req level / conv_ack pulse):
//   conv_req rises in the same cycle as tick and stays high until the edge
//   that samples conv_ack; it is low from the following cycle. At most one
//   request is ever outstanding. A tick that meets a still-high conv_req with
//   no ack on that edge is an overrun: it is counted and merged into the
//   pending request. A tick and an ack on the same edge retire the old request
//   and issue the new one, so conv_req simply stays high and nothing is
//   counted. An ack while conv_req is low is ignored.
// -----------------------------------------------------------------------------
module sample_tick_gen
    import sample_tick_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEF,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF,
    parameter int OVR_W      = OVR_W_DEF
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              enable,
    input  logic [CNT_W-1:0]  period_in,
    input  logic              clear_ovr,
    input  logic              conv_ack,
    output logic              tick,
    output logic              conv_req,
    output logic [OVR_W-1:0]  overrun_cnt,
    output logic              active,
    output tick_state_t       state_dbg
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] MIN_P     = CNT_W'(MIN_PERIOD);
    localparam logic [OVR_W-1:0] OVR_ZERO  = '0;
    localparam logic [OVR_W-1:0] OVR_ONE   = OVR_W'(1);
    localparam logic [OVR_W-1:0] OVR_MAX   = '1;

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    tick_state_t        state_q;
    tick_state_t        state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   period_q;      // period currently being counted out
    logic [CNT_W-1:0]   period_d;

    logic               tick_d;
    logic               req_d;
    logic [OVR_W-1:0]   ovr_d;
    logic               active_d;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0]   period_clamped;
    logic [CNT_W-1:0]   last_cnt;
    logic               start;         // IDLE edge that launches the timebase
    logic               fire;          // this edge closes a period
    logic               overrun;       // this edge's tick finds a pending request

    // period_in is only looked at through this clamp, and only on the edges
    // that load period_q (start and fire), so upstream changes mid-period are
    // invisible to the running count.
    always_comb begin
        period_clamped = period_in;
        if (period_in < MIN_P) begin
            period_clamped = MIN_P;
        end
    end

    // period_q >= MIN_PERIOD >= 2, so this never wraps below zero.
    assign last_cnt = period_q - CNT_ONE;

    assign start   = (state_q == IDLE) && enable;

    // The disabling edge never fires, even if it lands on the boundary.
    assign fire    = (state_q == RUN) && enable && (cnt_q == last_cnt);

    assign overrun = fire && conv_req && !conv_ack;

    // -------------------------------------------------------------------------
    // Process 1: state register and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            period_q    <= MIN_P;
            tick        <= 1'b0;
            conv_req    <= 1'b0;
            overrun_cnt <= OVR_ZERO;
            active      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            tick        <= tick_d;
            conv_req    <= req_d;
            overrun_cnt <= ovr_d;
            active      <= active_d;
        end
    end

    assign state_dbg = state_q;

    // -------------------------------------------------------------------------
    // Process 2: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    // A request acked on the very edge that disables us is
                    // already retired; waiting for another ack would hang.
                    if (conv_req && !conv_ack) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                // enable is deliberately not looked at here: the timebase only
                // restarts from IDLE with a fresh period load.
                if (conv_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Process 3: next values of counter, period and outputs
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = CNT_ZERO;
                if (enable) begin
                    period_d = period_clamped;
                end
            end
            RUN: begin
                if (!enable) begin
                    cnt_d = CNT_ZERO;
                end else if (fire) begin
                    cnt_d    = CNT_ZERO;
                    period_d = period_clamped;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            DRAIN: begin
                cnt_d = CNT_ZERO;
            end
            default: begin
                cnt_d = CNT_ZERO;
            end
        endcase
    end

    always_comb begin
        tick_d = fire;

        // A tick always leaves a request pending; otherwise an ack retires it.
        // In IDLE conv_req is already low, so an ack there changes nothing.
        req_d = conv_req;
        if (fire) begin
            req_d = 1'b1;
        end else if (conv_ack) begin
            req_d = 1'b0;
        end

        // clear_ovr and a new run both restart the count, and both win over
        // an overrun landing on the same edge.
        ovr_d = overrun_cnt;
        if (clear_ovr || start) begin
            ovr_d = OVR_ZERO;
        end else if (overrun && (overrun_cnt != OVR_MAX)) begin
            ovr_d = overrun_cnt + OVR_ONE;
        end

        active_d = (state_d != IDLE);
    end

endmodule : sample_tick_gen

// File: tb/tb_sample_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_sample_tick_gen
//
// Two instances share all inputs: the default configuration and one with a
// 3-bit overrun counter. A time-based model (absolute cycle of the next
// boundary, one pending-request flag, an unbounded overrun tally) predicts
// every output each cycle; directed sections pin tick positions and counts
// with hand-computed literals, then a randomized section stresses the rest.
// -----------------------------------------------------------------------------
module tb_sample_tick_gen;
  import sample_tick_pkg::*;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] period_in = 32'd100;
  logic        clear_ovr = 1'b0;
  logic        conv_ack = 1'b0;

  logic        tick, conv_req, active;
  logic [15:0] overrun_cnt;
  tick_state_t state_dbg;

  logic        s_tick, s_req, s_active;
  logic [2:0]  s_ovr;
  tick_state_t s_state;

  always #5 clk = ~clk;

  sample_tick_gen dut (
    .aclk(clk), .aresetn(aresetn), .enable(enable), .period_in(period_in),
    .clear_ovr(clear_ovr), .conv_ack(conv_ack), .tick(tick),
    .conv_req(conv_req), .overrun_cnt(overrun_cnt), .active(active),
    .state_dbg(state_dbg)
  );

  sample_tick_gen #(.OVR_W(3)) dut_sat (
    .aclk(clk), .aresetn(aresetn), .enable(enable), .period_in(period_in),
    .clear_ovr(clear_ovr), .conv_ack(conv_ack), .tick(s_tick),
    .conv_req(s_req), .overrun_cnt(s_ovr), .active(s_active),
    .state_dbg(s_state)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_miss = 0;
  logic [31:0] exp_q[$];
  logic [31:0] tick_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic check_ticks(input string name, input int e0);
    int n;
    chk({name, "_count"}, 64'(tick_q.size()), 64'(exp_q.size()));
    n = (tick_q.size() < exp_q.size()) ? tick_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk({name, "_offset"}, 64'(tick_q[i] - 32'(e0)), 64'(exp_q[i]));
    exp_q.delete();
    tick_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a run starting at edge n0 fires at n0+P, then every
  // newly sampled period after that; one pending request at most.
  // ---------------------------------------------------------------------------
  int m_mode = 0;       // 0 stopped, 1 running, 2 waiting for ack after disable
  int m_now = 0;
  int m_next = 0;
  int e_ovr = 0;
  bit e_tick = 0, e_req = 0, e_active = 0;

  function automatic int clamp_p(input logic [31:0] p);
    return (p < 32'd2) ? 2 : int'(p);
  endfunction

  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      m_mode = 0; e_tick = 0; e_req = 0; e_ovr = 0; e_active = 0;
    end else begin
      m_now++;
      e_tick = 0;
      if (m_mode == 0) begin
        if (enable) begin
          m_mode = 1;
          m_next = m_now + clamp_p(period_in);
          e_ovr = 0;
        end
      end else if (m_mode == 1) begin
        if (!enable) begin
          m_mode = (e_req && !conv_ack) ? 2 : 0;
          if (conv_ack) e_req = 0;
        end else if (m_now == m_next) begin
          e_tick = 1;
          m_next = m_now + clamp_p(period_in);
          if (e_req && !conv_ack) e_ovr++;
          e_req = 1;
        end else if (conv_ack) begin
          e_req = 0;
        end
      end else begin
        if (conv_ack) begin
          m_mode = 0;
          e_req = 0;
        end
      end
      if (clear_ovr) e_ovr = 0;
      e_active = (m_mode != 0);
    end
  end

  // Per-cycle compare, away from the active edge.
  always @(negedge clk) begin
    chk("tick", 64'(tick), 64'(e_tick));
    chk("conv_req", 64'(conv_req), 64'(e_req));
    chk("active", 64'(active), 64'(e_active));
    chk("state", 64'(state_dbg), 64'(m_mode));
    chk("overrun_cnt", 64'(overrun_cnt), 64'((e_ovr > 65535) ? 65535 : e_ovr));
    chk("sat_overrun_cnt", 64'(s_ovr), 64'((e_ovr > 7) ? 7 : e_ovr));
    chk("sat_conv_req", 64'(s_req), 64'(e_req));
    if (tick) tick_q.push_back(32'(cyc));
  end

  // ---------------------------------------------------------------------------
  // Converter responder: 0 = manual pulse, 1 = fixed delay, 2 = random
  // ---------------------------------------------------------------------------
  int ack_mode = 0;
  int ack_delay = 3;
  bit ack_pulse = 0;
  int age = 0;

  always @(posedge clk) begin
    #2;
    if (!aresetn) begin
      conv_ack = 1'b0;
      age = 0;
    end else if (ack_mode == 0) begin
      conv_ack = ack_pulse;
      ack_pulse = 0;
    end else if (ack_mode == 1) begin
      if (conv_ack) begin
        conv_ack = 1'b0;
        age = 1;
      end else if (conv_req) begin
        age++;
        if (age >= ack_delay) conv_ack = 1'b1;
      end else begin
        age = 0;
      end
    end else begin
      conv_ack = ($urandom_range(0, 3) == 0);
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic goto(input int e);
    int guard = 0;
    while (cyc < e && guard < 20000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc < e) chk("goto_timeout", 64'(cyc), 64'(e));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    aresetn = 1'b0;
    enable = 1'b0;
    clear_ovr = 1'b0;
    ack_pulse = 0;
    @(posedge clk);
    #1;
    aresetn = 1'b1;
    tick_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int e0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tick", 64'(tick), 64'd0);
    chk("rst_conv_req", 64'(conv_req), 64'd0);
    chk("rst_overrun_cnt", 64'(overrun_cnt), 64'd0);
    chk("rst_active", 64'(active), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'(IDLE));
    aresetn = 1'b1;

    // Period 100, ack three cycles after each request.
    ack_mode = 1; ack_delay = 3; period_in = 32'd100;
    tick_q.delete();
    enable = 1'b1; e0 = cyc + 1;
    goto(e0 + 305);
    exp_q = '{32'd100, 32'd200, 32'd300};
    check_ticks("p100", e0);
    chk("p100_overrun_cnt", 64'(overrun_cnt), 64'd0);

    // Mid-period change 100 -> 200 at cycle 50.
    do_reset();
    period_in = 32'd100; enable = 1'b1; e0 = cyc + 1;
    goto(e0 + 49);
    period_in = 32'd200;
    goto(e0 + 305);
    exp_q = '{32'd100, 32'd300};
    check_ticks("midchg", e0);

    // Clamp: period 0 then 1 both give a period of 2.
    do_reset();
    ack_delay = 1; period_in = 32'd0; enable = 1'b1; e0 = cyc + 1;
    goto(e0 + 6);
    period_in = 32'd1;
    goto(e0 + 13);
    exp_q = '{32'd2, 32'd4, 32'd6, 32'd8, 32'd10, 32'd12};
    check_ticks("clamp", e0);

    // No ack, period 4, ten ticks -> nine overruns; 3-bit copy saturates.
    do_reset();
    ack_mode = 0; period_in = 32'd4; enable = 1'b1; e0 = cyc + 1;
    goto(e0 + 41);
    for (int i = 1; i <= 10; i++) exp_q.push_back(32'(4 * i));
    check_ticks("ovr", e0);
    chk("ovr_overrun_cnt", 64'(overrun_cnt), 64'd9);
    chk("ovr_sat_overrun_cnt", 64'(s_ovr), 64'd7);
    chk("ovr_conv_req", 64'(conv_req), 64'd1);

    // Ack always lands on the tick edge -> request stays up, no overruns.
    do_reset();
    ack_mode = 1; ack_delay = 4; period_in = 32'd4; enable = 1'b1; e0 = cyc + 1;
    goto(e0 + 41);
    for (int i = 1; i <= 10; i++) exp_q.push_back(32'(4 * i));
    check_ticks("coinc", e0);
    chk("coinc_overrun_cnt", 64'(overrun_cnt), 64'd0);
    chk("coinc_conv_req", 64'(conv_req), 64'd1);

    // Disable at 150 with a request pending, ack at 160.
    do_reset();
    ack_mode = 0; period_in = 32'd100; enable = 1'b1; e0 = cyc + 1;
    goto(e0 + 149);
    enable = 1'b0;
    goto(e0 + 159);
    chk("drain_active", 64'(active), 64'd1);
    chk("drain_conv_req", 64'(conv_req), 64'd1);
    chk("drain_state", 64'(state_dbg), 64'(DRAIN));
    ack_pulse = 1;
    goto(e0 + 160);
    chk("drained_active", 64'(active), 64'd0);
    chk("drained_conv_req", 64'(conv_req), 64'd0);
    goto(e0 + 210);
    exp_q = '{32'd100};
    check_ticks("drain", e0);

    // Async reset at count 37 of the second period with a request pending.
    do_reset();
    period_in = 32'd100; enable = 1'b1; e0 = cyc + 1;
    goto(e0 + 137);
    chk("prerst_conv_req", 64'(conv_req), 64'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst_tick", 64'(tick), 64'd0);
    chk("arst_conv_req", 64'(conv_req), 64'd0);
    chk("arst_overrun_cnt", 64'(overrun_cnt), 64'd0);
    chk("arst_active", 64'(active), 64'd0);
    tick_q.delete();
    @(posedge clk);
    #1;
    aresetn = 1'b1; e0 = cyc + 1;
    goto(e0 + 101);
    exp_q = '{32'd100};
    check_ticks("rerun", e0);

    // Randomized traffic against the model.
    do_reset();
    ack_mode = 2; enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 60) == 0) enable = ~enable;
      if ($urandom_range(0, 7) == 0) period_in = 32'($urandom_range(0, 9));
      clear_ovr = ($urandom_range(0, 40) == 0);
    end
    clear_ovr = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_sample_tick_gen

// File: doc/sample_tick_gen.md
# sample_tick_gen

- Consumer end of the scale-to-period lookup: turns a sampling period in clock cycles (`time_sampling`, e.g. 100 … 10 000 000) into a strictly periodic conversion trigger.
- Each trigger becomes a request to the AD7276 acquisition front end over a level req / pulse ack handshake.
- Period changes are applied glitch-free at the next period boundary.
- Triggers lost because the converter has not acknowledged the previous request are counted as overruns.

## Interface
- `CNT_W`, default 32: width of period input and internal counter.
- `MIN_PERIOD`, default 2: smallest period honoured; smaller inputs are clamped up to it.
- `OVR_W`, default 16: overrun counter width.

- `aclk` in 1: single clock, all logic rising-edge.
- `aresetn` in 1: reset, asynchronous, active-low.
- `enable` in 1: level; high runs the timebase.
- `period_in` in CNT_W: desired period in aclk cycles; may change at any time.
- `clear_ovr` in 1: one-cycle pulse; clears `overrun_cnt`.
- `conv_ack` in 1: one-cycle pulse from converter; accepts the pending request.
- `tick` out 1: one-cycle pulse, once per period.
- `conv_req` out 1: level; high from tick until acknowledged.
- `overrun_cnt` out OVR_W: saturating count of ticks that found `conv_req` still high.
- `active` out 1: high in RUN or DRAIN.

## Operation
- Three states:
  - IDLE: counter held at 0. `enable`=1 moves to RUN, loads `period_act` = max(`period_in`, MIN_PERIOD), cnt=0 and clears `overrun_cnt`.
  - RUN: cnt increments by 1 each cycle.
    - When cnt == `period_act`-1, the cycle fires: cnt wraps to 0, `period_act` reloads from the clamped `period_in`, and `tick` pulses.
    - `enable`=0 goes to DRAIN if `conv_req`=1, otherwise to IDLE. No tick is issued on the disabling edge.
  - DRAIN: no counting and no ticks. Waits for `conv_ack`, then goes to IDLE. `enable` re-asserting in DRAIN is ignored until IDLE is reached.
- `period_in` is sampled only on entry to RUN and at wrap. Mid-period changes never shorten or stretch the current period.
- Request handshake, evaluated per cycle:
  - tick=1 and `conv_req`=0: `conv_req` rises.
  - tick=1, `conv_req`=1, `conv_ack`=0: overrun. `overrun_cnt` +1, saturating at 2^OVR_W-1. `conv_req` stays high, so only one request is outstanding.
  - tick=1 and `conv_ack`=1 in the same cycle: the old request completes and the new one is issued. `conv_req` stays high and no overrun is counted.
  - `conv_ack` with no tick: `conv_req` falls.
  - `conv_ack` while `conv_req`=0: ignored.
- `clear_ovr` coinciding with an overrun: the clear wins and the counter becomes 0.
- Arithmetic: the counter is CNT_W bits, compared against `period_act`-1. `period_act` ≥ MIN_PERIOD ≥ 2, so there is no underflow.

## Timing
- Reset values, applied asynchronously:
  - state=IDLE, cnt=0, `period_act`=MIN_PERIOD.
  - `tick`=0, `conv_req`=0, `overrun_cnt`=0, `active`=0.
- All outputs are registered.
- Edge E0 samples `enable`=1 in IDLE. `active` is high from E0.
  - First `tick` is high in the cycle after edge E0+P.
  - Following ticks are exactly P cycles apart.
- `conv_req` rises in the same cycle as `tick`.
- `conv_req` falls in the cycle after the edge sampling `conv_ack`.
- Assertion of `aresetn` mid-period or mid-request drops everything immediately. No pending-request drain occurs on reset.

## Structure
- Shared package `sample_tick_pkg`:
  - `tick_state_t` enum (IDLE, RUN, DRAIN).
  - `MIN_PERIOD_DEF`.
- No sub-module needed. Single always_ff plus a next-state always_comb.
- Intended to be instantiated beside the scale lookup block, with its `time_sampling` output driving `period_in`.

## Test plan
- Period and first tick: `period_in`=100, `enable` held high, `conv_ack` returned 3 cycles after each `conv_req` → ticks at cycles 101, 201, 301 after E0; `overrun_cnt`=0.
- Mid-period change: `period_in` changed from 100 to 200 at cycle 50 → next tick still at 101, then at 301.
- Clamp: `period_in`=0, then 1 → tick every 2 cycles.
- Overrun and saturation:
  - `conv_ack` never asserted, period 4, 10 ticks → `conv_req` stays high, `overrun_cnt`=9.
  - With OVR_W=3 → saturates at 7.
  - Simultaneous tick+ack → no increment.
- Disable during pending request: drop `enable` at cycle 150 with `conv_req`=1 → DRAIN, no further ticks; ack at 160 → IDLE, `active`=0 the cycle after.
- Async reset at mid-count 37 of 100 with `conv_req`=1 → all outputs 0 immediately; re-enable gives first tick P cycles later.
